fft_tile_scheduler: RTL and testbench

FFT_TILE_SCHEDULER -- requirements
Module: fft_tile_scheduler

---
 rtl/fftconv_pkg.sv | 39 +++
 rtl/tile_addr_gen.sv | 42 ++++
 rtl/fft_tile_scheduler.sv | 171 +++++++++++++++++
 tb/tb_fft_tile_scheduler.sv | 258 +++++++++++++++++++++++++
 4 files changed

// File: rtl/fftconv_pkg.sv
// Shared constants, state encoding and small arithmetic helpers for the
// FFT convolution tile scheduler.
package fftconv_pkg;

    localparam int IN_W  = 64;   // input image width/height
    localparam int OUT_W = 62;   // output image width/height
    localparam int T_IN  = 8;    // FFT tile input side
    localparam int T_OUT = 6;    // valid outputs per tile side
    localparam int NW    = 9;    // weight words per job
    localparam int TILES = 11;   // tiles per side, ceil(OUT_W/T_OUT)

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_WLOAD  = 3'd1,
        ST_TFETCH = 3'd2,
        ST_TRUN   = 3'd3,
        ST_TSTORE = 3'd4,
        ST_DONE   = 3'd5
    } state_e;

    // Plain vector constants so the state register stays a simple logic vector.
    localparam logic [2:0] S_IDLE   = ST_IDLE;
    localparam logic [2:0] S_WLOAD  = ST_WLOAD;
    localparam logic [2:0] S_TFETCH = ST_TFETCH;
    localparam logic [2:0] S_TRUN   = ST_TRUN;
    localparam logic [2:0] S_TSTORE = ST_TSTORE;
    localparam logic [2:0] S_DONE   = ST_DONE;

    // Quotient of a 0..35 result index by 6 without a divider.
    function automatic logic [2:0] div6(input logic [5:0] v);
        if (v >= 6'd30)      return 3'd5;
        else if (v >= 6'd24) return 3'd4;
        else if (v >= 6'd18) return 3'd3;
        else if (v >= 6'd12) return 3'd2;
        else if (v >= 6'd6)  return 3'd1;
        else                 return 3'd0;
    endfunction

endpackage

// File: rtl/tile_addr_gen.sv
// Tile address generator: maps (tx, ty, fetch index) to the input SRAM
// address plus zero-pad flag, and (tx, ty, result index) to the output
// SRAM address plus write mask. Purely combinational, 16-bit unsigned math.
module tile_addr_gen #(
    parameter int IN_W  = 64,
    parameter int OUT_W = 62
) (
    input  logic [3:0]  tx,
    input  logic [3:0]  ty,
    input  logic [5:0]  fetch_k,
    input  logic [5:0]  res_idx,
    output logic [15:0] input_addr,
    output logic        pad,
    output logic [15:0] output_addr,
    output logic        wmask
);
    import fftconv_pkg::*;

    logic [15:0] tx6, ty6;
    logic [15:0] row, col;
    logic [15:0] orow, ocol;
    logic [2:0]  ri, rj;

    // Tile origin, input-side row/col and output-side row/col, all via shifts.
    always_comb begin
        tx6  = ({12'd0, tx} << 2) + ({12'd0, tx} << 1);
        ty6  = ({12'd0, ty} << 2) + ({12'd0, ty} << 1);
        row  = ty6 + {13'd0, fetch_k[5:3]};
        col  = tx6 + {13'd0, fetch_k[2:0]};
        pad  = (row >= 16'(IN_W)) || (col >= 16'(IN_W));
        input_addr = (row << 6) + col;

        ri   = div6(res_idx);
        rj   = 3'(res_idx - ((6'(ri) << 2) + (6'(ri) << 1)));
        orow = ty6 + {13'd0, ri};
        ocol = tx6 + {13'd0, rj};
        wmask = (orow < 16'(OUT_W)) && (ocol < 16'(OUT_W));
        // row*62 = (row<<6) - (row<<1)
        output_addr = (orow << 6) - (orow << 1) + ocol;
    end

endmodule

// File: rtl/fft_tile_scheduler.sv
// FFT tile scheduler: loads the weights once, then for each of the 11x11
// tiles streams an 8x8 zero-padded input patch into the engine, kicks it,
// waits for completion and scatters the 6x6 valid results to output SRAM.
module fft_tile_scheduler #(
    parameter int IN_W  = fftconv_pkg::IN_W,
    parameter int OUT_W = fftconv_pkg::OUT_W,
    parameter int T_IN  = fftconv_pkg::T_IN,
    parameter int T_OUT = fftconv_pkg::T_OUT,
    parameter int NW    = fftconv_pkg::NW
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        valid,
    output logic        Ready,
    output logic [15:0] input_addr,
    input  logic [31:0] input_rdata,
    output logic [15:0] weight_addr,
    input  logic [31:0] weight_rdata,
    output logic        eng_ld,
    output logic        eng_ld_sel,
    output logic [5:0]  eng_ld_idx,
    output logic [31:0] eng_ld_data,
    output logic        eng_start,
    input  logic        eng_done,
    output logic [5:0]  eng_res_idx,
    input  logic [31:0] eng_res_data,
    output logic        output_wen,
    output logic [15:0] output_addr,
    output logic [31:0] output_wdata
);
    import fftconv_pkg::*;

    localparam int FETCH_N = T_IN * T_IN;                 // 64 input words per tile
    localparam int STORE_N = T_OUT * T_OUT;               // 36 result words per tile
    localparam int LAST_T  = (OUT_W + T_OUT - 1) / T_OUT - 1;

    logic [2:0]  state;
    logic [3:0]  tx, ty;
    logic [6:0]  k;

    // One-deep pipeline matching the SRAM read latency.
    logic        ld_vld, ld_sel, ld_pad;
    logic [5:0]  ld_idx;
    logic [15:0] input_addr_q;

    logic        wl_issue, tf_issue;
    logic [15:0] in_addr_calc, out_addr_calc;
    logic        pad, wmask;

    tile_addr_gen #(
        .IN_W  (IN_W),
        .OUT_W (OUT_W)
    ) u_addr (
        .tx          (tx),
        .ty          (ty),
        .fetch_k     (k[5:0]),
        .res_idx     (k[5:0]),
        .input_addr  (in_addr_calc),
        .pad         (pad),
        .output_addr (out_addr_calc),
        .wmask       (wmask)
    );

    // Read issue qualifiers and all outputs, decoded from state and the pipe.
    always_comb begin
        wl_issue     = (state == S_WLOAD)  && (k < 7'(NW));
        tf_issue     = (state == S_TFETCH) && (k < 7'(FETCH_N));
        weight_addr  = wl_issue ? {9'd0, k} : 16'd0;
        // Padded positions leave the input address where it was.
        input_addr   = (tf_issue && !pad) ? in_addr_calc : input_addr_q;
        eng_ld       = ld_vld;
        eng_ld_sel   = ld_sel;
        eng_ld_idx   = ld_idx;
        eng_ld_data  = !ld_vld ? 32'd0 :
                       ld_sel  ? weight_rdata :
                       ld_pad  ? 32'd0 : input_rdata;
        eng_start    = (state == S_TRUN) && (k == 7'd0);
        eng_res_idx  = (state == S_TSTORE) ? k[5:0] : 6'd0;
        output_wen   = (state == S_TSTORE) && wmask;
        output_addr  = (state == S_TSTORE) ? out_addr_calc : 16'd0;
        output_wdata = (state == S_TSTORE) ? eng_res_data : 32'd0;
        Ready        = (state == S_DONE);
    end

    // Load pipe: strobe the engine buffer one cycle after each SRAM address.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ld_vld       <= 1'b0;
            ld_sel       <= 1'b0;
            ld_pad       <= 1'b0;
            ld_idx       <= 6'd0;
            input_addr_q <= 16'd0;
        end else begin
            ld_vld       <= wl_issue || tf_issue;
            ld_sel       <= wl_issue;
            ld_pad       <= tf_issue && pad;
            ld_idx       <= (wl_issue || tf_issue) ? k[5:0] : 6'd0;
            input_addr_q <= input_addr;
        end
    end

    // Job FSM with the per-phase counter k and the tile walk over (tx, ty).
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= S_IDLE;
            tx    <= 4'd0;
            ty    <= 4'd0;
            k     <= 7'd0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (valid) begin
                        state <= S_WLOAD;
                        tx    <= 4'd0;
                        ty    <= 4'd0;
                        k     <= 7'd0;
                    end
                end
                S_WLOAD: begin
                    if (k == 7'(NW)) begin
                        state <= S_TFETCH;
                        k     <= 7'd0;
                    end else begin
                        k <= k + 7'd1;
                    end
                end
                S_TFETCH: begin
                    if (k == 7'(FETCH_N)) begin
                        state <= S_TRUN;
                        k     <= 7'd0;
                    end else begin
                        k <= k + 7'd1;
                    end
                end
                S_TRUN: begin
                    // k==0 marks the start cycle; a done seen there is stale.
                    if (k != 7'd0 && eng_done) begin
                        state <= S_TSTORE;
                        k     <= 7'd0;
                    end else begin
                        k <= 7'd1;
                    end
                end
                S_TSTORE: begin
                    if (k == 7'(STORE_N - 1)) begin
                        k <= 7'd0;
                        if (tx == 4'(LAST_T)) begin
                            tx <= 4'd0;
                            if (ty == 4'(LAST_T)) begin
                                state <= S_DONE;
                            end else begin
                                ty    <= ty + 4'd1;
                                state <= S_TFETCH;
                            end
                        end else begin
                            tx    <= tx + 4'd1;
                            state <= S_TFETCH;
                        end
                    end else begin
                        k <= k + 7'd1;
                    end
                end
                S_DONE: begin
                    if (!valid) state <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_fft_tile_scheduler.sv
// Directed bench for fft_tile_scheduler: SRAM and engine models, an output
// scoreboard, and one task per scenario.
module tb_fft_tile_scheduler;
    import fftconv_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        valid = 1'b0;
    logic        Ready;
    logic [15:0] input_addr, weight_addr, output_addr;
    logic [31:0] input_rdata = 32'd0, weight_rdata = 32'd0;
    logic        eng_ld, eng_ld_sel, eng_start, eng_done, output_wen;
    logic [5:0]  eng_ld_idx, eng_res_idx;
    logic [31:0] eng_ld_data, eng_res_data, output_wdata;

    int checks = 0;
    int passes = 0;
    int cyc = 0;
    logic job_clr = 1'b1;

    localparam int READY_CYC = 10 + 121 * (65 + 6 + 36);

    always #5 clk = ~clk;

    fft_tile_scheduler dut (
        .clk(clk), .rst(rst), .valid(valid), .Ready(Ready),
        .input_addr(input_addr), .input_rdata(input_rdata),
        .weight_addr(weight_addr), .weight_rdata(weight_rdata),
        .eng_ld(eng_ld), .eng_ld_sel(eng_ld_sel), .eng_ld_idx(eng_ld_idx),
        .eng_ld_data(eng_ld_data), .eng_start(eng_start), .eng_done(eng_done),
        .eng_res_idx(eng_res_idx), .eng_res_data(eng_res_data),
        .output_wen(output_wen), .output_addr(output_addr), .output_wdata(output_wdata)
    );

    // SRAMs: one-cycle read latency; input word = address, weight word tagged.
    always @(posedge clk) begin
        input_rdata  <= {16'd0, input_addr};
        weight_rdata <= 32'hA000_0000 | {16'd0, weight_addr};
    end

    // Engine: done level rises 5 cycles after start and stays until the next start.
    int eng_cnt = 0;
    int starts = 0;
    int cur_tile = 0;
    logic done_lvl = 1'b0;
    always @(posedge clk) begin
        if (job_clr) begin
            starts <= 0; eng_cnt <= 0; done_lvl <= 1'b0; cur_tile <= 0;
        end else if (eng_start) begin
            cur_tile <= starts; starts <= starts + 1; eng_cnt <= 5; done_lvl <= 1'b0;
        end else if (eng_cnt != 0) begin
            eng_cnt <= eng_cnt - 1;
            if (eng_cnt == 2) done_lvl <= 1'b1;
        end
    end
    assign eng_done = done_lvl;
    assign eng_res_data = {cur_tile[15:0], 10'd0, eng_res_idx};

    function automatic logic [31:0] exp_wdata(input int a);
        int row, col, t, idx;
        row = a / 62; col = a % 62;
        t   = (row / 6) * 11 + col / 6;
        idx = (row % 6) * 6 + col % 6;
        return {t[15:0], 10'd0, idx[5:0]};
    endfunction

    // Scoreboard over every output write, plus strobe exclusivity.
    bit seen [0:3843];
    int wr_count = 0, dup = 0, bad_addr = 0, data_err = 0, excl_err = 0;
    always @(negedge clk) begin
        if (job_clr) begin
            for (int i = 0; i < 3844; i++) seen[i] <= 1'b0;
            wr_count <= 0; dup <= 0; bad_addr <= 0; data_err <= 0; excl_err <= 0;
        end else if (!rst) begin
            if (int'(eng_ld) + int'(eng_start) + int'(output_wen) > 1) excl_err <= excl_err + 1;
            if (output_wen) begin
                wr_count <= wr_count + 1;
                if (output_addr >= 16'd3844) bad_addr <= bad_addr + 1;
                else begin
                    if (seen[output_addr]) dup <= dup + 1;
                    seen[output_addr] <= 1'b1;
                    if (output_wdata !== exp_wdata(int'(output_addr))) data_err <= data_err + 1;
                end
            end
        end
    end

    task automatic step();
        @(negedge clk);
        cyc++;
    endtask

    task automatic test_reset();
        step(); step();
        checks++; if (Ready !== 1'b0) $display("FAIL rst_ready got %b exp 0", Ready); else passes++;
        checks++; if ({eng_ld, eng_ld_sel, eng_ld_idx, eng_ld_data} !== 40'd0)
            $display("FAIL rst_ld got %b/%b/%0d/%h exp 0", eng_ld, eng_ld_sel, eng_ld_idx, eng_ld_data); else passes++;
        checks++; if ({eng_start, eng_res_idx, output_wen} !== 8'd0)
            $display("FAIL rst_eng got %b/%0d/%b exp 0", eng_start, eng_res_idx, output_wen); else passes++;
        checks++; if ({input_addr, weight_addr, output_addr, output_wdata} !== 80'd0)
            $display("FAIL rst_addr got %h/%h/%h/%h exp 0", input_addr, weight_addr, output_addr, output_wdata); else passes++;
        rst = 1'b0;
        step(); step();
        job_clr = 1'b0;
        step();
        checks++; if (dut.state !== S_IDLE || eng_ld !== 1'b0)
            $display("FAIL idle_wait got state %0d ld %b exp IDLE 0", dut.state, eng_ld); else passes++;
    endtask

    // Starts the job; cycle 0 is the first WLOAD cycle.
    task automatic test_wload();
        valid = 1'b1;
        step(); cyc = 0;
        for (int n = 0; n < 10; n++) begin
            if (n < 9) begin
                checks++; if (weight_addr !== 16'(n))
                    $display("FAIL wload_addr n=%0d got %0d exp %0d", n, weight_addr, n); else passes++;
            end
            checks++; if (eng_ld !== (n >= 1))
                $display("FAIL wload_ld n=%0d got %b exp %b", n, eng_ld, n >= 1); else passes++;
            if (n >= 1) begin
                checks++; if (eng_ld_sel !== 1'b1 || eng_ld_idx !== 6'(n - 1) || eng_ld_data !== (32'hA000_0000 | 32'(n - 1)))
                    $display("FAIL wload_data n=%0d got sel %b idx %0d data %h exp 1 %0d %h",
                             n, eng_ld_sel, eng_ld_idx, eng_ld_data, n - 1, 32'hA000_0000 | 32'(n - 1)); else passes++;
            end
            step();
        end
    endtask

    task automatic test_tile0();
        int npulse;
        for (int c = 0; c < 65; c++) begin
            if (c < 64) begin
                checks++; if (input_addr !== 16'((c / 8) * 64 + c % 8))
                    $display("FAIL fetch_addr k=%0d got %0d exp %0d", c, input_addr, (c / 8) * 64 + c % 8); else passes++;
            end
            if (c >= 1) begin
                checks++; if (eng_ld !== 1'b1 || eng_ld_sel !== 1'b0 || eng_ld_idx !== 6'(c - 1) ||
                              eng_ld_data !== 32'(((c - 1) / 8) * 64 + (c - 1) % 8))
                    $display("FAIL fetch_ld k=%0d got %b %b %0d %0d", c - 1, eng_ld, eng_ld_sel, eng_ld_idx, eng_ld_data); else passes++;
            end
            if (c == 10) begin
                checks++; if (eng_ld_data !== 32'd65)
                    $display("FAIL k9_data got %0d exp 65", eng_ld_data); else passes++;
            end
            step();
        end
        npulse = 0;
        checks++; if (eng_start !== 1'b1)
            $display("FAIL start_time cyc=%0d got %b exp 1", cyc, eng_start); else passes++;
        for (int t = 0; t < 6; t++) begin
            if (eng_start === 1'b1) npulse++;
            step();
        end
        checks++; if (npulse !== 1) $display("FAIL start_pulses got %0d exp 1", npulse); else passes++;
        checks++; if (output_wen !== 1'b1 || output_addr !== 16'd0 || eng_res_idx !== 6'd0)
            $display("FAIL store_first got wen %b addr %0d idx %0d exp 1 0 0", output_wen, output_addr, eng_res_idx); else passes++;
        repeat (7) step();
        checks++; if (output_addr !== 16'd63 || output_wdata !== 32'd7)
            $display("FAIL store_idx7 got addr %0d data %h exp 63 7", output_addr, output_wdata); else passes++;
    endtask

    task automatic test_valid_ignored();
        valid = 1'b0;
        while (cyc < 6000) step();
        checks++; if (dut.state === S_IDLE || Ready !== 1'b0)
            $display("FAIL valid_drop got state %0d ready %b exp busy", dut.state, Ready); else passes++;
        valid = 1'b1;
    endtask

    task automatic test_edge_tile();
        int ie, je;
        logic ew;
        while (cyc < 10 + 120 * 107) step();
        checks++; if (input_addr !== 16'd3900) $display("FAIL edge_k0 got %0d exp 3900", input_addr); else passes++;
        step();
        checks++; if (eng_ld_data !== 32'd3900) $display("FAIL edge_k0_data got %0d exp 3900", eng_ld_data); else passes++;
        repeat (3) step();
        checks++; if (input_addr !== 16'd3903) $display("FAIL edge_pad_hold got %0d exp 3903", input_addr); else passes++;
        step();
        checks++; if (eng_ld !== 1'b1 || eng_ld_idx !== 6'd4 || eng_ld_data !== 32'd0)
            $display("FAIL edge_pad_data got %b %0d %0d exp 1 4 0", eng_ld, eng_ld_idx, eng_ld_data); else passes++;
        while (cyc < 10 + 120 * 107 + 71) step();
        for (int idx = 0; idx < 36; idx++) begin
            ie = idx / 6; je = idx % 6;
            ew = (ie < 2) && (je < 2);
            checks++; if (output_wen !== ew)
                $display("FAIL edge_wen idx=%0d got %b exp %b", idx, output_wen, ew); else passes++;
            if (ew) begin
                checks++; if (output_addr !== 16'(3780 + ie * 62 + je))
                    $display("FAIL edge_waddr idx=%0d got %0d exp %0d", idx, output_addr, 3780 + ie * 62 + je); else passes++;
            end
            step();
        end
    endtask

    task automatic check_job_end(input string tag);
        while (!Ready && cyc < READY_CYC + 50) step();
        checks++; if (cyc !== READY_CYC)
            $display("FAIL %s_ready_time got %0d exp %0d", tag, cyc, READY_CYC); else passes++;
        step(); step();
        checks++; if (wr_count !== 3844) $display("FAIL %s_writes got %0d exp 3844", tag, wr_count); else passes++;
        checks++; if (dup !== 0 || bad_addr !== 0) $display("FAIL %s_unique got dup %0d bad %0d exp 0", tag, dup, bad_addr); else passes++;
        checks++; if (data_err !== 0) $display("FAIL %s_wdata got %0d errors exp 0", tag, data_err); else passes++;
        checks++; if (excl_err !== 0) $display("FAIL %s_exclusive got %0d overlaps exp 0", tag, excl_err); else passes++;
    endtask

    task automatic test_done_hold();
        repeat (5) step();
        checks++; if (Ready !== 1'b1) $display("FAIL done_hold got %b exp 1", Ready); else passes++;
        valid = 1'b0;
        step();
        checks++; if (Ready !== 1'b0 || dut.state !== S_IDLE)
            $display("FAIL done_release got ready %b state %0d exp 0 IDLE", Ready, dut.state); else passes++;
    endtask

    task automatic test_rst_midjob();
        job_clr = 1'b1; step(); step(); job_clr = 1'b0;
        valid = 1'b1;
        step(); cyc = 0;
        while (cyc < 10 + 25 * 107 + 71 + 10) step();
        checks++; if (output_wen !== 1'b1 || output_addr !== 16'd828)
            $display("FAIL pre_rst_store got wen %b addr %0d exp 1 828", output_wen, output_addr); else passes++;
        rst = 1'b1;
        #1;
        checks++; if (output_wen !== 1'b0 || eng_res_idx !== 6'd0)
            $display("FAIL rst_async_wen got %b idx %0d exp 0 0", output_wen, eng_res_idx); else passes++;
        valid = 1'b0;
        job_clr = 1'b1;
        step(); step();
        rst = 1'b0;
        repeat (5) step();
        job_clr = 1'b0;
        checks++; if (dut.state !== S_IDLE || eng_ld !== 1'b0 || weight_addr !== 16'd0)
            $display("FAIL rst_idle got state %0d ld %b waddr %0d exp IDLE", dut.state, eng_ld, weight_addr); else passes++;
        valid = 1'b1;
        step(); cyc = 0;
        checks++; if (dut.state !== S_WLOAD || weight_addr !== 16'd0)
            $display("FAIL restart_wload got state %0d waddr %0d exp WLOAD 0", dut.state, weight_addr); else passes++;
        check_job_end("rerun");
        valid = 1'b0;
        step();
    endtask

    initial begin
        test_reset();
        test_wload();
        test_tile0();
        test_valid_ignored();
        test_edge_tile();
        check_job_end("job1");
        test_done_hold();
        test_rst_midjob();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
